// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared definitions for the PLL lock supervisor.
//   pll_state_e      2-bit supervisor state, encoding visible on out_state
//   RELOCK_CNT_W     width of the optional lock-loss statistics counter
//   pll_reset_for()  PLL RESET pin level implied by a state
package pll_sup_pkg;

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAIL      = 2'd3
  } pll_state_e;

  localparam int RELOCK_CNT_W = 8;

  // The PLL is held in reset while re-arming and while parked in FAIL.
  function automatic logic pll_reset_for(input pll_state_e s);
    return (s == ST_RESET_PLL) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   i_clk  destination clock
//   i_rst  asynchronous active-high reset, clears both flops
//   i_d    asynchronous input
//   o_q    synchronized output, two destination-clock cycles of latency
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for a stable lock, retries
// on timeout and parks in FAIL after MAX_RETRIES failed attempts.
//   in_clk_27mhz      reference clock, all logic on its rising edge
//   in_reset          asynchronous active-high reset
//   in_pll_lock       PLL LOCK, asynchronous, synchronized internally
//   in_relock_req     single-cycle request to restart the lock sequence
//   out_pll_reset     PLL RESET pin (active-high)
//   out_sys_reset     reset for PLL-clocked logic (low only in RUN)
//   out_locked        high only in RUN
//   out_fail          high only in FAIL
//   out_state         current state encoding (pll_state_e)
//   out_relock_count  saturating count of lock-loss exits from RUN; present
//                     only when PLL_SUPERVISOR_STATS_EN is defined
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int MAX_RETRIES    = 4
) (
  input  logic       in_clk_27mhz,
  input  logic       in_reset,
  input  logic       in_pll_lock,
  input  logic       in_relock_req,
  output logic       out_pll_reset,
  output logic       out_sys_reset,
  output logic       out_locked,
  output logic       out_fail,
  output logic [1:0] out_state
`ifdef PLL_SUPERVISOR_STATS_EN
  ,
  output logic [RELOCK_CNT_W-1:0] out_relock_count
`endif
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(MAX_RETRIES + 1);

  localparam logic [RW-1:0] RST_LAST    = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [NW-1:0] RETRY_MAX   = NW'(MAX_RETRIES);

  logic          w_lock_s;
  pll_state_e    r_state,       w_state_nxt;
  logic [RW-1:0] r_rst_cnt,     w_rst_cnt_nxt;
  logic [SW-1:0] r_stable_cnt,  w_stable_nxt;
  logic [TW-1:0] r_timeout_cnt, w_timeout_nxt;
  logic [NW-1:0] r_retry_cnt,   w_retry_nxt, w_retry_inc;
  logic          r_pll_reset, r_sys_reset, r_locked, r_fail;

  sync_2ff u_lock_sync (
    .i_clk (in_clk_27mhz),
    .i_rst (in_reset),
    .i_d   (in_pll_lock),
    .o_q   (w_lock_s)
  );

  always_ff @(posedge in_clk_27mhz or posedge in_reset) begin
    if (in_reset) r_state <= ST_RESET_PLL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_stable_nxt  = r_stable_cnt;
    w_timeout_nxt = r_timeout_cnt;
    w_retry_nxt   = r_retry_cnt;
    // Only used in WAIT_LOCK, where r_retry_cnt < MAX_RETRIES, so no wrap.
    w_retry_inc   = r_retry_cnt + 1'b1;
    case (r_state)
      ST_RESET_PLL: begin
        if (in_relock_req)               w_rst_cnt_nxt = '0;
        else if (r_rst_cnt == RST_LAST)  w_state_nxt   = ST_WAIT_LOCK;
        else                             w_rst_cnt_nxt = r_rst_cnt + 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (in_relock_req) begin
          w_state_nxt = ST_RESET_PLL;
        end else if (r_stable_cnt == STABLE_MAX) begin
          // Checked before timeout: a lock completing on the timeout cycle wins.
          w_state_nxt = ST_RUN;
          w_retry_nxt = '0;
        end else if (r_timeout_cnt == TIMEOUT_MAX) begin
          w_retry_nxt = w_retry_inc;
          w_state_nxt = (w_retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
        end else begin
          // Both counters are below their limits here, so +1 cannot wrap.
          w_stable_nxt  = w_lock_s ? r_stable_cnt + 1'b1 : '0;
          w_timeout_nxt = r_timeout_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_lock_s || in_relock_req) w_state_nxt = ST_RESET_PLL;
      end
      ST_FAIL: begin
        if (in_relock_req) begin
          w_state_nxt = ST_RESET_PLL;
          w_retry_nxt = '0;
        end
      end
      default: w_state_nxt = ST_RESET_PLL;
    endcase
    // Every entry into RESET_PLL, including a relock restart, starts with
    // full counts.
    if (w_state_nxt == ST_RESET_PLL && (r_state != ST_RESET_PLL || in_relock_req)) begin
      w_rst_cnt_nxt = '0;
      w_stable_nxt  = '0;
      w_timeout_nxt = '0;
    end
    if (r_state == ST_RESET_PLL && w_state_nxt == ST_WAIT_LOCK) w_rst_cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as out_state.
  always_ff @(posedge in_clk_27mhz or posedge in_reset) begin
    if (in_reset) begin
      r_rst_cnt     <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_retry_cnt   <= '0;
      r_pll_reset   <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_locked      <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_rst_cnt     <= w_rst_cnt_nxt;
      r_stable_cnt  <= w_stable_nxt;
      r_timeout_cnt <= w_timeout_nxt;
      r_retry_cnt   <= w_retry_nxt;
      r_pll_reset   <= pll_reset_for(w_state_nxt);
      r_sys_reset   <= (w_state_nxt != ST_RUN);
      r_locked      <= (w_state_nxt == ST_RUN);
      r_fail        <= (w_state_nxt == ST_FAIL);
    end
  end

  assign out_pll_reset = r_pll_reset;
  assign out_sys_reset = r_sys_reset;
  assign out_locked    = r_locked;
  assign out_fail      = r_fail;
  assign out_state     = r_state;

`ifdef PLL_SUPERVISOR_STATS_EN
  logic [RELOCK_CNT_W-1:0] r_relock_count;

  // In RUN a low synchronized lock always forces RESET_PLL, so this is
  // exactly the set of lock-loss exits.
  always_ff @(posedge in_clk_27mhz or posedge in_reset) begin
    if (in_reset)
      r_relock_count <= '0;
    else if (r_state == ST_RUN && !w_lock_s && r_relock_count != '1)
      r_relock_count <= r_relock_count + 1'b1;
  end

  assign out_relock_count = r_relock_count;
`else
  // Statistics disabled: no lock-loss counter and no extra port.
`endif

endmodule
